apb_multi_tgt_bridge: RTL and testbench
=======================================

// Module: apb_multi_tgt_bridge
// PURPOSE
//  APB4 slave bridge that decodes each transfer onto one of NUM_TGT local request/ready targets.
//  Adds PSTRB forwarding, per-target error return, unmapped-address error and a wait-state
//  timeout with PSLVERR. Sits between the AMBA APB interconnect and register-mapped IP blocks.
// PARAMETERS
//  ADDR_WIDTH  32      APB address width
//  DATA_WIDTH  32      APB data width (multiple of 8)
//  NUM_TGT     4       number of local targets, 1..16
//  SEL_LSB     12      LSB of target-index field in PADDR (4 KB window per target)
//  TIMEOUT     255     max REQ-state cycles before abort, 1..65535; 0 = timeout disabled
// PORTS
//  i_clk         in   1                  clock
//  i_reset_n     in   1                  async active-low reset
//  i_psel        in   1                  APB select
//  i_penable     in   1                  APB enable
//  i_pwrite      in   1                  APB direction, 1 = write
//  i_paddr       in   ADDR_WIDTH         APB address
//  i_pwdata      in   DATA_WIDTH         APB write data
//  i_pstrb       in   DATA_WIDTH/8       APB byte strobes (ignored on reads)
//  o_pready      out  1                  APB ready
//  o_prdata      out  DATA_WIDTH         APB read data
//  o_pslverr     out  1                  APB slave error
//  o_req_valid   out  NUM_TGT            one-hot request to target t
//  o_req_write   out  1                  request direction
//  o_req_addr    out  ADDR_WIDTH         full latched PADDR
//  o_req_wdata   out  DATA_WIDTH         latched PWDATA
//  o_req_strb    out  DATA_WIDTH/8       latched PSTRB; all-zero on reads
//  i_req_ready   in   NUM_TGT            target t accepts/completes request
//  i_req_rdata   in   NUM_TGT*DATA_WIDTH read data, target t at [t*DATA_WIDTH +: DATA_WIDTH]
//  i_req_err     in   NUM_TGT            target t error, sampled with i_req_ready[t]
//  o_timeout     out  1                  one-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset i_reset_n, asynchronous, active-low; clock i_clk. All outputs registered, all reset to 0; FSM -> IDLE.
//  Decode: IDX_W = max(1,clog2(NUM_TGT)); idx = PADDR[SEL_LSB +: IDX_W]. Unmapped if idx >= NUM_TGT
//   or any PADDR bit above SEL_LSB+IDX_W is 1.
//  FSM IDLE/REQ/RESP:
//   IDLE: on psel & !penable (setup): latch addr/write/wdata/strb/idx. Mapped -> REQ, o_req_valid[idx]=1
//     next cycle. Unmapped -> RESP with pslverr=1, no o_req_valid asserted.
//   REQ: o_req_valid[idx] held high, request fields stable. Only i_req_ready[idx]/i_req_err[idx] sampled;
//     other targets' inputs ignored. On i_req_ready[idx]=1: o_req_valid->0,
//     prdata<=slice idx (reads only; writes leave prdata unchanged), pslverr<=i_req_err[idx], -> RESP.
//     Wait counter (16 bit) clears on REQ entry, increments each REQ cycle without ready. When it
//     reaches TIMEOUT: o_req_valid->0, pslverr<=1, o_timeout pulse, -> RESP. Ready wins if coincident.
//   RESP: o_pready=1 for exactly one cycle with o_pslverr; then pready/pslverr->0, -> IDLE.
//  Latency: setup T0, req_valid T1; ready at T1 -> pready at T2 (min 1 APB wait state). Ready at T1+n -> pready T2+n.
//  Back-to-back: new setup phase accepted in the cycle after RESP (IDLE).
//  Abort: psel=0 while in REQ -> o_req_valid->0, -> IDLE, no pready, no pslverr, no o_timeout.
//  In RESP, psel is not checked; pready is always issued.
//  Setup phase with penable=1 in IDLE is ignored.
//  o_prdata holds its last value between transfers; it changes only on a read completion.
//  Reset mid-transfer: all outputs to 0 immediately, FSM to IDLE.
// TESTING
//  1. Write 0xDEADBEEF to 0x0000_1010, strb 0xF, tgt1 ready at T1 -> o_req_valid=4'b0010 for 1 cycle,
//     o_req_strb=0xF, pready at T2, pslverr=0.
//  2. Read 0x0000_3004, tgt3 ready after 5 cycles with rdata 0x12345678 -> prdata=0x12345678,
//     pready 6 cycles after T1, pslverr=0.
//  3. Read 0x0001_0000 (upper bit set) and NUM_TGT=3 read of 0x0000_3000 -> no req_valid,
//     pready at T1 with pslverr=1.
//  4. TIMEOUT=8, tgt0 never ready -> req_valid low after 8 REQ cycles, o_timeout pulse,
//     pready+pslverr next cycle; next transfer completes normally.
//  5. Write with i_req_err[2]=1 alongside ready -> pslverr=1; tgt0 ready/err toggling during tgt2 access is ignored.
//  6. psel dropped in REQ, and i_reset_n asserted in REQ -> req_valid->0, no pready, FSM back in IDLE.

Source files
------------

// File: rtl/apb_multi_tgt_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : apb_multi_tgt_bridge
//  Description : APB4 slave that routes each transfer to one of NUM_TGT local
//                request/ready targets, selected by a PADDR index field.
//                Unmapped addresses, target errors and wait-state timeouts
//                are all reported through PSLVERR.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_multi_tgt_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_TGT    = 4,
  parameter int SEL_LSB    = 12,
  parameter int TIMEOUT    = 255
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_psel,
  input  logic                          i_penable,
  input  logic                          i_pwrite,
  input  logic [ADDR_WIDTH-1:0]         i_paddr,
  input  logic [DATA_WIDTH-1:0]         i_pwdata,
  input  logic [DATA_WIDTH/8-1:0]       i_pstrb,
  output logic                          o_pready,
  output logic [DATA_WIDTH-1:0]         o_prdata,
  output logic                          o_pslverr,
  output logic [NUM_TGT-1:0]            o_req_valid,
  output logic                          o_req_write,
  output logic [ADDR_WIDTH-1:0]         o_req_addr,
  output logic [DATA_WIDTH-1:0]         o_req_wdata,
  output logic [DATA_WIDTH/8-1:0]       o_req_strb,
  input  logic [NUM_TGT-1:0]            i_req_ready,
  input  logic [NUM_TGT*DATA_WIDTH-1:0] i_req_rdata,
  input  logic [NUM_TGT-1:0]            i_req_err,
  output logic                          o_timeout
);

  localparam int          STRB_W    = DATA_WIDTH / 8;
  localparam int          IDX_W     = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int          HI_LSB    = SEL_LSB + IDX_W;
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic [NUM_TGT-1:0]      req_valid_q, req_valid_d;
  logic                    req_write_q, req_write_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]   req_wdata_q, req_wdata_d;
  logic [STRB_W-1:0]       req_strb_q, req_strb_d;
  logic                    timeout_q, timeout_d;
  logic [15:0]             cnt_q, cnt_d;

  logic [IDX_W-1:0]        w_idx;
  logic                    w_hi_zero;
  logic [NUM_TGT-1:0]      w_dec_oh;
  logic                    w_mapped;
  logic                    w_sel_ready;
  logic                    w_sel_err;
  logic [DATA_WIDTH-1:0]   w_sel_rdata;
  logic [15:0]             w_cnt_inc;
  logic                    w_cnt_hit;

  assign w_idx = i_paddr[SEL_LSB +: IDX_W];

  // Address bits above the index field must all be zero for a mapped access.
  if (HI_LSB < ADDR_WIDTH) begin : g_hi_chk
    assign w_hi_zero = ~|i_paddr[ADDR_WIDTH-1:HI_LSB];
  end else begin : g_hi_none
    assign w_hi_zero = 1'b1;
  end

  // Decode the index field into a one-hot target select; indices past NUM_TGT decode to zero.
  always_comb begin
    w_dec_oh = '0;
    for (int t = 0; t < NUM_TGT; t++) begin
      if (32'(w_idx) == 32'(t)) begin
        w_dec_oh[t] = 1'b1;
      end
    end
  end

  assign w_mapped = w_hi_zero & (|w_dec_oh);

  // Only the active target's handshake and data are visible; the one-hot valid masks the rest.
  always_comb begin
    w_sel_rdata = '0;
    for (int t = 0; t < NUM_TGT; t++) begin
      if (req_valid_q[t]) begin
        w_sel_rdata = w_sel_rdata | i_req_rdata[t*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_sel_ready = |(i_req_ready & req_valid_q);
  assign w_sel_err   = |(i_req_err & req_valid_q);
  assign w_cnt_inc   = cnt_q + 16'd1;
  assign w_cnt_hit   = (TIMEOUT != 0) && (w_cnt_inc == TIMEOUT_C);

  // Next-state and next-output logic for the IDLE/REQ/RESP transfer sequencer.
  always_comb begin
    state_d     = state_q;
    pready_d    = pready_q;
    pslverr_d   = pslverr_q;
    prdata_d    = prdata_q;
    req_valid_d = req_valid_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_strb_d  = req_strb_q;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        // Only a genuine setup phase starts a transfer; a stray access phase is ignored.
        if (i_psel && !i_penable) begin
          req_addr_d  = i_paddr;
          req_write_d = i_pwrite;
          req_wdata_d = i_pwdata;
          req_strb_d  = i_pwrite ? i_pstrb : '0;
          cnt_d       = '0;
          if (w_mapped) begin
            req_valid_d = w_dec_oh;
            state_d     = S_REQ;
          end else begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            state_d   = S_RESP;
          end
        end
      end

      S_REQ: begin
        if (!i_psel) begin
          // Master abandoned the transfer: withdraw the request silently.
          req_valid_d = '0;
          state_d     = S_IDLE;
        end else if (w_sel_ready) begin
          // Ready has priority over a timeout reached in the same cycle.
          req_valid_d = '0;
          if (!req_write_q) begin
            prdata_d = w_sel_rdata;
          end
          pslverr_d = w_sel_err;
          pready_d  = 1'b1;
          state_d   = S_RESP;
        end else if (w_cnt_hit) begin
          req_valid_d = '0;
          pslverr_d   = 1'b1;
          pready_d    = 1'b1;
          timeout_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end

      S_RESP: begin
        // Response is always completed, regardless of psel.
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        state_d   = S_IDLE;
      end

      default: begin
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        req_valid_d = '0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and registered-output flops; everything clears asynchronously on reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      req_valid_q <= '0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_strb_q  <= '0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      prdata_q    <= prdata_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_strb_q  <= req_strb_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_pready    = pready_q;
  assign o_pslverr   = pslverr_q;
  assign o_prdata    = prdata_q;
  assign o_req_valid = req_valid_q;
  assign o_req_write = req_write_q;
  assign o_req_addr  = req_addr_q;
  assign o_req_wdata = req_wdata_q;
  assign o_req_strb  = req_strb_q;
  assign o_timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_multi_tgt_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_apb_multi_tgt_bridge
//  Description : Self-checking bench for apb_multi_tgt_bridge. A 4-target
//                instance (TIMEOUT=8) carries all traffic; a 3-target
//                instance on the same APB bus checks the index range limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_multi_tgt_bridge;

  localparam int NT = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          psel, penable, pwrite;
  logic [31:0]   paddr, pwdata;
  logic [3:0]    pstrb;
  logic          pready, pslverr, tmo, req_write;
  logic [31:0]   prdata, req_addr, req_wdata;
  logic [3:0]    req_valid, req_strb, req_ready, req_err;
  logic [127:0]  req_rdata;

  logic          pready3, pslverr3, tmo3, req_write3;
  logic [31:0]   prdata3, req_addr3, req_wdata3;
  logic [2:0]    req_valid3;
  logic [3:0]    req_strb3;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [31:0]   exp_prdata = 32'h0;

  always #5 clk = ~clk;

  apb_multi_tgt_bridge #(.NUM_TGT(NT), .TIMEOUT(TO)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_psel(psel), .i_penable(penable),
    .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_pready(pready), .o_prdata(prdata), .o_pslverr(pslverr),
    .o_req_valid(req_valid), .o_req_write(req_write), .o_req_addr(req_addr),
    .o_req_wdata(req_wdata), .o_req_strb(req_strb), .i_req_ready(req_ready),
    .i_req_rdata(req_rdata), .i_req_err(req_err), .o_timeout(tmo)
  );

  apb_multi_tgt_bridge #(.NUM_TGT(3), .TIMEOUT(TO)) u_dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_psel(psel), .i_penable(penable),
    .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_pready(pready3), .o_prdata(prdata3), .o_pslverr(pslverr3),
    .o_req_valid(req_valid3), .o_req_write(req_write3), .o_req_addr(req_addr3),
    .o_req_wdata(req_wdata3), .o_req_strb(req_strb3), .i_req_ready(3'b111),
    .i_req_rdata(96'h0), .i_req_err(3'b000), .o_timeout(tmo3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random ready/err/rdata on every target other than the addressed one.
  task automatic drive_noise(input int tgt);
    for (int t = 0; t < NT; t++) begin
      if (t != tgt) begin
        req_ready[t]          = 1'($urandom_range(0, 1));
        req_err[t]            = 1'($urandom_range(0, 1));
        req_rdata[t*32 +: 32] = $urandom();
      end
    end
  endtask

  // One APB transfer, starting in a cycle where the bridge is idle.
  // lat: cycles after the first request cycle before the target raises ready (>=TO: never).
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int lat, input logic err,
                      input logic [31:0] rdata);
    bit          mapped, mapped3, exp_to;
    int          tgt, k;
    logic        exp_err;
    logic [3:0]  exp_oh;
    logic [2:0]  exp_oh3;
    mapped  = (addr >> 12) < NT;
    mapped3 = (addr >> 12) < 3;
    tgt     = int'(addr[13:12]);
    exp_oh  = mapped ? (4'b0001 << tgt) : 4'b0000;
    exp_oh3 = mapped3 ? (3'b001 << tgt) : 3'b000;
    if (!mapped) begin
      k = 0; exp_err = 1'b1; exp_to = 1'b0;
    end else if (lat < TO) begin
      k = lat + 1; exp_err = err; exp_to = 1'b0;
    end else begin
      k = TO; exp_err = 1'b1; exp_to = 1'b1;
    end

    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    req_ready = '0; req_err = '0;
    drive_noise(mapped ? tgt : -1);
    tick();

    for (int c = 0; c <= k; c++) begin
      if (c == 0) begin
        check_eq("t3_pready", pready3, !mapped3);
        check_eq("t3_pslverr", pslverr3, !mapped3);
        check_eq("t3_req_valid", req_valid3, exp_oh3);
        if (mapped) begin
          check_eq("req_addr", req_addr, addr);
          check_eq("req_write", req_write, wr);
          check_eq("req_wdata", req_wdata, wdata);
          check_eq("req_strb", req_strb, wr ? strb : 4'h0);
        end
      end
      if (c < k) begin
        check_eq("wait_pready", pready, 1'b0);
        check_eq("wait_req_valid", req_valid, exp_oh);
        check_eq("wait_timeout", tmo, 1'b0);
      end else begin
        if (mapped && lat < TO && !wr) exp_prdata = rdata;
        check_eq("resp_pready", pready, 1'b1);
        check_eq("resp_pslverr", pslverr, exp_err);
        check_eq("resp_timeout", tmo, exp_to);
        check_eq("resp_req_valid", req_valid, 4'h0);
        check_eq("resp_prdata", prdata, exp_prdata);
      end
      penable = 1'b1;
      if (c == k) begin
        psel = 1'b0; penable = 1'b0;
      end
      req_ready = '0; req_err = '0;
      drive_noise(mapped ? tgt : -1);
      if (mapped) begin
        req_ready[tgt]          = (c == lat);
        req_err[tgt]            = err && (c == lat);
        req_rdata[tgt*32 +: 32] = (c == lat) ? rdata : $urandom();
      end
      tick();
    end

    check_eq("idle_pready", pready, 1'b0);
    check_eq("idle_pslverr", pslverr, 1'b0);
    check_eq("idle_timeout", tmo, 1'b0);
    check_eq("idle_prdata", prdata, exp_prdata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          lat;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    req_ready = '0; req_err = '0; req_rdata = '0;
    tick(); tick();
    check_eq("rst_pready", pready, 1'b0);
    check_eq("rst_pslverr", pslverr, 1'b0);
    check_eq("rst_prdata", prdata, 32'h0);
    check_eq("rst_req_valid", req_valid, 4'h0);
    check_eq("rst_req_addr", req_addr, 32'h0);
    check_eq("rst_timeout", tmo, 1'b0);
    rst_n = 1'b1;
    tick();

    // Directed cases
    xfer(32'h0000_1010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0);
    xfer(32'h0000_3004, 1'b0, 32'h0BAD_F00D, 4'hF, 5, 1'b0, 32'h1234_5678);
    xfer(32'h0001_0000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'hAAAA_5555);
    xfer(32'h0000_3000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h5A5A_A5A5);
    xfer(32'h0000_2000, 1'b1, 32'h1111_2222, 4'h3, 1, 1'b0, 32'h0);
    xfer(32'h0000_0100, 1'b0, 32'h0, 4'hF, 100, 1'b0, 32'hFFFF_0000);
    xfer(32'h0000_0104, 1'b0, 32'h0, 4'hF, 2, 1'b0, 32'hCAFE_0001);
    xfer(32'h0000_1008, 1'b0, 32'h0, 4'hF, TO - 1, 1'b0, 32'hCAFE_0007);
    xfer(32'h0000_2008, 1'b1, 32'h7777_8888, 4'hA, 2, 1'b1, 32'h0);
    xfer(32'h8000_0000, 1'b1, 32'h1, 4'hF, 0, 1'b0, 32'h0);

    // Abort by dropping psel while the request is outstanding
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_2040;
    req_ready = '0; req_err = '0;
    tick();
    check_eq("abort_req_valid_t1", req_valid, 4'b0100);
    penable = 1'b1;
    tick();
    check_eq("abort_req_valid_t2", req_valid, 4'b0100);
    psel = 1'b0; penable = 1'b0;
    tick();
    check_eq("abort_req_valid", req_valid, 4'h0);
    check_eq("abort_pready", pready, 1'b0);
    check_eq("abort_pslverr", pslverr, 1'b0);
    check_eq("abort_timeout", tmo, 1'b0);
    tick();
    check_eq("abort_pready2", pready, 1'b0);
    xfer(32'h0000_2044, 1'b0, 32'h0, 4'hF, 1, 1'b0, 32'hB0B0_B0B0);

    // Reset while the request is outstanding
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_1000; pwdata = 32'h55;
    req_ready = '0; req_err = '0;
    tick();
    penable = 1'b1;
    tick();
    check_eq("prerst_req_valid", req_valid, 4'b0010);
    rst_n = 1'b0;
    #2;
    check_eq("midrst_req_valid", req_valid, 4'h0);
    check_eq("midrst_pready", pready, 1'b0);
    check_eq("midrst_prdata", prdata, 32'h0);
    check_eq("midrst_req_addr", req_addr, 32'h0);
    exp_prdata = 32'h0;
    psel = 1'b0; penable = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("postrst_pready", pready, 1'b0);
    xfer(32'h0000_3010, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h600D_600D);

    // Randomized traffic, back-to-back
    for (int i = 0; i < 150; i++) begin
      a = (32'($urandom_range(0, 5)) << 12) | (32'($urandom_range(0, 1023)) << 2);
      if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(14, 31));
      lat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TO, TO + 4))
                                        : int'($urandom_range(0, TO - 1));
      xfer(a, 1'($urandom_range(0, 1)), $urandom(), 4'($urandom_range(0, 15)), lat,
           ($urandom_range(0, 3) == 0), $urandom());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
